// File: rtl/lru_replacement_client_pkg.sv
// replacement_client_pkg: request opcodes and FSM states shared by the LRU replacement client.
package replacement_client_pkg;
    typedef enum logic [1:0] {
        OP_HIT        = 2'd0,
        OP_MISS       = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_NONE       = 2'd3
    } replacement_op_t;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        VICTIM,
        FILL_REQ,
        FILL_WAIT,
        COMMIT
    } replacement_client_state_t;
endpackage

// File: rtl/lru_replacement_client_if.sv
// ReplacementAlgorithmInterface: link between a replacement client and the set-associative LRU.
interface ReplacementAlgorithmInterface #(parameter int NUMBER_OF_CACHE_LINES = 4);
    localparam int COUNTER_WIDTH = $clog2(NUMBER_OF_CACHE_LINES);
    logic                     accessEnable;
    logic                     invalidateEnable;
    logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine;
    logic [COUNTER_WIDTH-1:0] replacementCacheLine;
    modport master (output accessEnable, invalidateEnable, lastAccessedCacheLine, input replacementCacheLine);
    modport slave (input accessEnable, invalidateEnable, lastAccessedCacheLine, output replacementCacheLine);
endinterface

// File: rtl/lru_replacement_client_saturating_counter.sv
// saturating_counter: up-counter that sticks at its all-ones maximum.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge clock or posedge reset)
        if (reset) value <= '0;
        else if (increment && !(&value)) value <= value + 1'b1;
endmodule

// File: rtl/lru_replacement_client.sv
// lru_replacement_client: sequences hit/miss/invalidate requests into LRU pulses and a victim fill handshake.
module lru_replacement_client
    import replacement_client_pkg::*;
#(
    parameter int INDEX_WIDTH           = 6,
    parameter int NUMBER_OF_CACHE_LINES = 4,
    parameter int MISS_COUNT_WIDTH      = 16,
    localparam int COUNTER_WIDTH        = $clog2(NUMBER_OF_CACHE_LINES)
) (
    input  logic                        clock,
    input  logic                        reset,
    ReplacementAlgorithmInterface.master replacementAlgorithmInterface,
    output logic [INDEX_WIDTH-1:0]      indexOut,
    input  logic                        reqValid,
    output logic                        reqReady,
    input  replacement_op_t             reqOp,
    input  logic [INDEX_WIDTH-1:0]      reqIndex,
    input  logic [COUNTER_WIDTH-1:0]    reqLine,
    output logic                        fillValid,
    input  logic                        fillReady,
    output logic [INDEX_WIDTH-1:0]      fillIndex,
    output logic [COUNTER_WIDTH-1:0]    fillLine,
    input  logic                        fillDone,
    output logic                        busy,
    output logic [MISS_COUNT_WIDTH-1:0] missCount
);
    replacement_client_state_t state, nextState;
    logic [COUNTER_WIDTH-1:0] victimReg;
    logic [COUNTER_WIDTH-1:0] nextLine;
    logic nextAccess, nextInvalidate, accept;

    assign accept    = reqValid && reqReady;
    assign reqReady  = state == IDLE;
    assign busy      = !reqReady;
    assign fillValid = state == FILL_REQ;
    assign fillIndex = indexOut;
    assign fillLine  = victimReg;

    // Pulses are registered from the next-state decode so the LRU sees glitch-free enables.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state                                       <= IDLE;
            replacementAlgorithmInterface.accessEnable     <= 1'b0;
            replacementAlgorithmInterface.invalidateEnable <= 1'b0;
            replacementAlgorithmInterface.lastAccessedCacheLine <= '0;
        end else begin
            state                                       <= nextState;
            replacementAlgorithmInterface.accessEnable     <= nextAccess;
            replacementAlgorithmInterface.invalidateEnable <= nextInvalidate;
            replacementAlgorithmInterface.lastAccessedCacheLine <= nextLine;
        end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (accept) nextState = reqOp == OP_MISS ? VICTIM : reqOp == OP_NONE ? IDLE : UPDATE;
            VICTIM:    nextState = FILL_REQ;
            FILL_REQ:  if (fillReady) nextState = FILL_WAIT;
            FILL_WAIT: if (fillDone) nextState = COMMIT;
            default:   nextState = IDLE;
        endcase
    end

    // UPDATE is only ever entered from IDLE, so reqOp/reqLine are the accepted request's fields.
    always_comb begin
        nextAccess     = (nextState == UPDATE && reqOp == OP_HIT) || nextState == COMMIT;
        nextInvalidate = nextState == UPDATE && reqOp == OP_INVALIDATE;
        nextLine       = nextState == UPDATE ? reqLine :
                         nextState == COMMIT ? victimReg :
                         replacementAlgorithmInterface.lastAccessedCacheLine;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            indexOut  <= '0;
            victimReg <= '0;
        end else begin
            if (accept) indexOut <= reqIndex;
            if (state == VICTIM) victimReg <= replacementAlgorithmInterface.replacementCacheLine;
        end

    saturating_counter #(.WIDTH(MISS_COUNT_WIDTH)) missCounter (
        .clock     (clock),
        .reset     (reset),
        .increment (accept && reqOp == OP_MISS),
        .value     (missCount)
    );
endmodule

// File: doc/lru_replacement_client.md
Name: lru_replacement_client

Overview:
- Master-side client of ReplacementAlgorithmInterface; sits between the cache controller and the set-associative LRU.
- Converts controller requests (hit, miss, invalidate) into correctly sequenced accessEnable/invalidateEnable pulses.
- Drives the set index into the LRU and holds it stable while the LRU is in use.
- On a miss, captures the victim line from replacementCacheLine, runs a fill handshake, then commits the victim as most-recently-used.

Parameters:
- INDEX_WIDTH, 6, set index width; number of sets = 2**INDEX_WIDTH.
- NUMBER_OF_CACHE_LINES, 4, ways per set; must be a power of two, at least 2.
- COUNTER_WIDTH, $clog2(NUMBER_OF_CACHE_LINES), way-number width; derived, not overridable.
- MISS_COUNT_WIDTH, 16, width of the saturating miss counter.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- replacementAlgorithmInterface  master modport  ReplacementAlgorithmInterface#(NUMBER_OF_CACHE_LINES)  drives accessEnable, invalidateEnable, lastAccessedCacheLine; reads replacementCacheLine
- indexOut  out  INDEX_WIDTH  set index for the LRU (its cpuIndexIn)
- reqValid  in  1  controller request valid
- reqReady  out  1  client can accept a request
- reqOp  in  2  request operation, encoded as replacement_op_t
- reqIndex  in  INDEX_WIDTH  request set
- reqLine  in  COUNTER_WIDTH  way for a hit or an invalidate; ignored for a miss
- fillValid  out  1  fill request valid
- fillReady  in  1  fill engine accepts the request
- fillIndex  out  INDEX_WIDTH  set to fill
- fillLine  out  COUNTER_WIDTH  victim way to fill
- fillDone  in  1  one-cycle pulse: fill complete
- busy  out  1  high whenever state is not IDLE
- missCount  out  MISS_COUNT_WIDTH  saturating count of accepted misses

Behaviour:
- Reset: async, active-high. Forces state IDLE and clears all registers. Output values during reset:
  - reqReady=1, busy=0, fillValid=0
  - accessEnable=0, invalidateEnable=0, lastAccessedCacheLine=0
  - indexOut=0, fillIndex=0, fillLine=0, missCount=0
- Reset mid-operation: any pending fill is abandoned and no commit pulse is issued.
- Request acceptance:
  - A request is accepted on a rising edge with reqValid && reqReady.
  - reqReady = (state==IDLE).
  - On acceptance, reqIndex latches into indexOut and reqLine latches into lineReg.
  - indexOut stays constant until the state returns to IDLE.
- Encodings:
  - reqOp: OP_HIT=0, OP_MISS=1, OP_INVALIDATE=2, OP_NONE=3.
  - OP_NONE is accepted and dropped: no pulse, state stays IDLE.
- States and transitions:
  - IDLE -> UPDATE on an accepted OP_HIT or OP_INVALIDATE.
  - IDLE -> VICTIM on an accepted OP_MISS; missCount increments, saturating at its maximum.
  - UPDATE (1 cycle):
    - HIT: accessEnable=1 with lastAccessedCacheLine=lineReg.
    - INVALIDATE: invalidateEnable=1 with lastAccessedCacheLine=lineReg.
    - Then -> IDLE.
  - VICTIM (1 cycle): indexOut has been stable since acceptance, so replacementCacheLine is sampled into victimReg at the end of this cycle. -> FILL_REQ.
  - FILL_REQ:
    - fillValid=1, fillIndex=indexOut, fillLine=victimReg.
    - These values are held until fillReady. On fillValid && fillReady -> FILL_WAIT.
  - FILL_WAIT: waits for fillDone, then -> COMMIT.
    - fillDone is sampled only in this state; a fillDone in FILL_REQ, including one coincident with the handshake, is ignored.
  - COMMIT (1 cycle): accessEnable=1 with lastAccessedCacheLine=victimReg. -> IDLE.
- Pulse rules:
  - accessEnable and invalidateEnable are never high together.
  - Each pulse lasts exactly one cycle.
  - Both are driven from state registers (glitch-free) and are otherwise 0.
- lastAccessedCacheLine holds its last value outside the pulse cycles.
- Latency and throughput:
  - Hit or invalidate: pulse in the cycle after acceptance; the next request can be accepted 2 cycles after the previous acceptance.
  - Miss: minimum 4 cycles from acceptance to commit, assuming fillReady in the first FILL_REQ cycle and fillDone in the first FILL_WAIT cycle.
- Inputs are don't-care outside the acceptance edge.
- missCount at its maximum (65535 by default) stays at that value.

Decomposition:
- Package replacement_client_pkg holds:
  - replacement_op_t, a 2-bit enum: OP_HIT, OP_MISS, OP_INVALIDATE, OP_NONE.
  - replacement_client_state_t: IDLE, UPDATE, VICTIM, FILL_REQ, FILL_WAIT, COMMIT.
- Sub-module saturating_counter (parameter WIDTH; ports clock, reset, increment, value). Reusable for other statistics.
- Everything else stays in a single FSM module.

Test Plan:
- Reset asserted mid-FILL_WAIT -> all outputs return to reset values immediately, without waiting for a clock edge. After release, no accessEnable pulse; reqReady=1; missCount=0.
- HIT at index 5, line 2 -> indexOut=5. accessEnable=1 and lastAccessedCacheLine=2 for exactly one cycle, one cycle after acceptance. reqReady low for 1 cycle.
- INVALIDATE at index 63, line 3 -> invalidateEnable=1 for one cycle with lastAccessedCacheLine=3, accessEnable=0 throughout. The model LRU marks line 3 of set 63 as the next victim.
- MISS at index 10, model replacementCacheLine=1, fillReady delayed 3 cycles, fillDone 5 cycles later:
  - fillValid held with fillIndex=10, fillLine=1 until the handshake.
  - indexOut stable at 10 throughout.
  - accessEnable pulse with line 1 in the cycle after fillDone; missCount=1.
- fillDone pulsed in the same cycle as the fillValid/fillReady handshake, then again 2 cycles later -> the first pulse is ignored; commit follows the second.
- 65537 back-to-back misses with instant fill -> missCount saturates at 65535. OP_NONE requests produce no pulses and leave missCount unchanged.
